// File: rtl/wrr_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wrr_arbiter_if : request/weight/grant bundle for the weighted RR arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface wrr_arbiter_if #(
  parameter int REQS = 4,
  parameter int WW   = 3
);
  localparam int IDW = (REQS > 1) ? $clog2(REQS) : 1;

  logic [REQS-1:0]    req;
  logic [REQS*WW-1:0] weight;
  logic [REQS-1:0]    grant;
  logic [IDW-1:0]     grant_id;
  logic               grant_valid;

  modport master (
    output req,
    output weight,
    input  grant,
    input  grant_id,
    input  grant_valid
  );

  modport slave (
    input  req,
    input  weight,
    output grant,
    output grant_id,
    output grant_valid
  );
endinterface
`default_nettype wire

// File: rtl/wrr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wrr_arbiter : weighted round-robin arbiter, registered one-hot grant
// Revision: 1.0
// ---------------------------------------------------------------------------
module wrr_arbiter #(
  parameter int REQS = 4,
  parameter int WW   = 3
) (
  input  logic         clk,
  input  logic         rst,
  wrr_arbiter_if.slave bus
);
  localparam int IDW = (REQS > 1) ? $clog2(REQS) : 1;
  localparam logic [2*REQS-1:0] ONE2 = {{(2*REQS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          state_q,    state_d;
  logic [REQS-1:0] grant_q,    grant_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [IDW-1:0]  last_q,     last_d;
  logic [WW-1:0]   credit_q,   credit_d;

  logic [IDW-1:0]    w_start;
  logic [2*REQS-1:0] w_dbl;
  logic [2*REQS-1:0] w_mask;
  logic [2*REQS-1:0] w_masked;
  logic [2*REQS-1:0] w_lsb;
  logic [REQS-1:0]   w_win;
  logic [IDW-1:0]    w_win_id;
  logic [WW-1:0]     w_win_wt;
  logic              w_hold;

  // Circular search: duplicate req, mask off bits below the start index,
  // isolate the lowest remaining bit and fold both halves back together.
  always_comb begin
    w_start  = (last_q == IDW'(REQS-1)) ? '0 : last_q + IDW'(1);
    w_dbl    = {bus.req, bus.req};
    w_mask   = ~((ONE2 << w_start) - ONE2);
    w_masked = w_dbl & w_mask;
    w_lsb    = w_masked & (~w_masked + ONE2);
    w_win    = w_lsb[REQS-1:0] | w_lsb[2*REQS-1:REQS];
    w_win_id = '0;
    w_win_wt = '0;
    for (int i = 0; i < REQS; i++) begin
      if (w_win[i]) begin
        w_win_id = IDW'(i);
        w_win_wt = bus.weight[i*WW +: WW];
      end
    end
  end

  assign w_hold = (state_q == S_GRANT) && bus.req[grant_id_q] && (credit_q > WW'(1));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    credit_d   = credit_q;
    if (w_hold) begin
      credit_d = credit_q - WW'(1);
    end else if (bus.req == '0) begin
      state_d    = S_IDLE;
      grant_d    = '0;
      grant_id_d = '0;
    end else begin
      state_d    = S_GRANT;
      grant_d    = w_win;
      grant_id_d = w_win_id;
      last_d     = w_win_id;
      credit_d   = (w_win_wt == '0) ? WW'(1) : w_win_wt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= IDW'(REQS-1);
      credit_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      credit_q   <= credit_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = (state_q == S_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wrr_arbiter : directed bench for wrr_arbiter at REQS=4 and REQS=5
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_wrr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic started = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wrr_arbiter_if #(.REQS(4), .WW(3)) if4 ();
  wrr_arbiter_if #(.REQS(5), .WW(3)) if5 ();

  wrr_arbiter #(.REQS(4), .WW(3)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  wrr_arbiter #(.REQS(5), .WW(3)) u_dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

  // Reference: current grantee (-1 = none), last winner, remaining cycles.
  int m_g[2];
  int m_last[2];
  int m_credit[2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_g[k]      = -1;
      m_last[k]   = (k == 0) ? 3 : 4;
      m_credit[k] = 0;
    end
  endtask

  task automatic m_step(input int k, input int n, input logic [7:0] rq, input logic [23:0] wv);
    int  g;
    int  c;
    int  wt;
    bit  found;
    g = m_g[k];
    if (g >= 0 && rq[g] && m_credit[k] > 1) begin
      m_credit[k] = m_credit[k] - 1;
    end else begin
      found = 1'b0;
      for (int off = 1; off <= n; off++) begin
        c = (m_last[k] + off) % n;
        if (!found && rq[c]) begin
          found       = 1'b1;
          wt          = int'((wv >> (3 * c)) & 24'd7);
          m_g[k]      = c;
          m_last[k]   = c;
          m_credit[k] = (wt == 0) ? 1 : wt;
        end
      end
      if (!found) m_g[k] = -1;
    end
  endtask

  initial m_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else begin
      m_step(0, 4, {4'b0, if4.req}, {12'b0, if4.weight});
      m_step(1, 5, {3'b0, if5.req}, {9'b0, if5.weight});
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("m4.grant", 32'(if4.grant),       (m_g[0] >= 0) ? (32'd1 << m_g[0]) : 32'd0);
      chk("m4.id",    32'(if4.grant_id),    (m_g[0] >= 0) ? 32'(m_g[0]) : 32'd0);
      chk("m4.valid", 32'(if4.grant_valid), 32'(m_g[0] >= 0));
      chk("m5.grant", 32'(if5.grant),       (m_g[1] >= 0) ? (32'd1 << m_g[1]) : 32'd0);
      chk("m5.id",    32'(if5.grant_id),    (m_g[1] >= 0) ? 32'(m_g[1]) : 32'd0);
      chk("m5.valid", 32'(if5.grant_valid), 32'(m_g[1] >= 0));
    end
  end

  task automatic apply(input logic [3:0] rq);
    if4.req    = rq;
    if5.req    = {rq[0] | rq[3], rq};
    if5.weight = {3'd2, if4.weight};
    @(posedge clk);
    #1;
  endtask

  task automatic apply5(input logic [4:0] rq);
    if5.req = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [3:0] eg, input logic [1:0] eid);
    chk({name, ".grant"}, 32'(if4.grant),       32'(eg));
    chk({name, ".id"},    32'(if4.grant_id),    32'(eid));
    chk({name, ".valid"}, 32'(if4.grant_valid), 32'(eg != 4'b0));
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    if4.req = '0;
    if5.req = '0;
    @(posedge clk);
    #1;
    rst     = 1'b1;
  endtask

  initial begin
    if4.req    = '0;
    if4.weight = {4{3'd1}};
    if5.req    = '0;
    if5.weight = {5{3'd1}};
    @(posedge clk);
    #1;
    started = 1'b1;
    lit("reset", 4'b0000, 2'd0);
    do_reset();

    // 1: sanity, single requesters
    apply(4'b0001); lit("t1a", 4'b0001, 2'd0);
    apply(4'b0010); lit("t1b", 4'b0010, 2'd1);
    apply(4'b0100); lit("t1c", 4'b0100, 2'd2);
    apply(4'b1000); lit("t1d", 4'b1000, 2'd3);
    apply(4'b0000); lit("t1e", 4'b0000, 2'd0);

    // 2: fair rotation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(4'b1111);
      lit("t2", 4'b0001 << (i % 4), 2'(i % 4));
    end

    // 3: weighted rotation
    do_reset();
    if4.weight = {3'd1, 3'd2, 3'd1, 3'd3};
    begin
      logic [3:0] exp3 [10];
      exp3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100,
               4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
      for (int i = 0; i < 10; i++) begin
        apply(4'b1111);
        chk("t3.grant", 32'(if4.grant), 32'(exp3[i]));
      end
    end

    // 4: early drop, weight 0 acts as 1
    do_reset();
    if4.weight = {3'd1, 3'd1, 3'd0, 3'd4};
    apply(4'b0011); lit("t4a", 4'b0001, 2'd0);
    apply(4'b0011); lit("t4b", 4'b0001, 2'd0);
    apply(4'b0010); lit("t4c", 4'b0010, 2'd1);
    apply(4'b0010); lit("t4d", 4'b0010, 2'd1);
    apply(4'b0000); lit("t4e", 4'b0000, 2'd0);

    // 5: lone requester then idle
    do_reset();
    if4.weight = {4{3'd1}};
    for (int i = 0; i < 4; i++) begin
      apply(4'b0100); lit("t5", 4'b0100, 2'd2);
    end
    apply(4'b0000); lit("t5idle", 4'b0000, 2'd0);

    // 6: reset during a burst
    do_reset();
    if4.weight = {3'd1, 3'd1, 3'd1, 3'd5};
    apply(4'b1101); lit("t6a", 4'b0001, 2'd0);
    apply(4'b1101); lit("t6b", 4'b0001, 2'd0);
    rst = 1'b0;
    #1;
    lit("t6rst", 4'b0000, 2'd0);
    @(posedge clk);
    #1;
    lit("t6rst2", 4'b0000, 2'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(4'b1101); lit("t6burst", 4'b0001, 2'd0);
    end
    apply(4'b1101); lit("t6c", 4'b0100, 2'd2);
    apply(4'b1101); lit("t6d", 4'b1000, 2'd3);
    apply(4'b1101); lit("t6e", 4'b0001, 2'd0);

    // 7: five requesters, wrap from index 4 back to 0
    do_reset();
    if5.weight = {5{3'd1}};
    for (int i = 0; i < 6; i++) begin
      apply5(5'b11111);
      chk("t7.grant", 32'(if5.grant),    32'd1 << (i % 5));
      chk("t7.id",    32'(if5.grant_id), 32'(i % 5));
    end
    apply5(5'b10000); chk("t7.lone", 32'(if5.grant), 32'h10);
    apply5(5'b00001); chk("t7.wrap", 32'(if5.grant), 32'h01);
    apply5(5'b00000); chk("t7.idle", 32'(if5.grant_valid), 32'd0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
